// File: rtl/distance_mac.sv
// Three-stage signed multiply-accumulate that sums SPECTRAL_BANDS products per pixel.
// Optional clamping on overflow is enabled by defining DISTANCE_MAC_SATURATE_EN.
module distance_mac #(
    parameter int SPECTRAL_BANDS = 100,
    parameter int MAC_WIDTH      = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAC_WIDTH-1:0] op_a,
    input  logic [MAC_WIDTH-1:0] op_b,
    input  logic                 op_valid,
    input  logic                 acc_clear,
    output logic [MAC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    output logic                 acc_last,
    output logic                 overflow
);
    localparam int               CNT_W     = (SPECTRAL_BANDS > 1) ? $clog2(SPECTRAL_BANDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BAND = CNT_W'(SPECTRAL_BANDS - 1);
    localparam int               PW        = 2 * MAC_WIDTH;

`ifdef DISTANCE_MAC_SATURATE_EN
    localparam logic [MAC_WIDTH-1:0] POS_MAX = {1'b0, {(MAC_WIDTH-1){1'b1}}};
    localparam logic [MAC_WIDTH-1:0] NEG_MIN = {1'b1, {(MAC_WIDTH-1){1'b0}}};
`endif

    // ---------------- S1: operand capture ----------------
    logic [MAC_WIDTH-1:0] op_in  [2];
    logic [PW-1:0]        op_ext [2];
    logic                 s1_valid_reg;

    assign op_in[0] = op_a;
    assign op_in[1] = op_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [MAC_WIDTH-1:0] op_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_reg <= '0;
                end else if (op_valid) begin
                    op_reg <= op_in[gi];
                end
            end

            // Sign-extending to full width lets a plain multiply yield the exact signed product.
            assign op_ext[gi] = {{MAC_WIDTH{op_reg[MAC_WIDTH-1]}}, op_reg};
        end
    endgenerate

    // A pair presented together with acc_clear still enters as band 0 of the new sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= op_valid;
        end
    end

    // ---------------- S2: product ----------------
    logic [PW-1:0]        prod_full;
    logic                 prod_ovf;
    logic [MAC_WIDTH-1:0] prod_next;
    logic [MAC_WIDTH-1:0] s2_prod_reg;
    logic                 s2_povf_reg;
    logic                 s2_valid_reg;

    assign prod_full = op_ext[0] * op_ext[1];
    // Product fits only if the kept sign bit and every discarded bit agree.
    assign prod_ovf  = !((&prod_full[PW-1:MAC_WIDTH-1]) || !(|prod_full[PW-1:MAC_WIDTH-1]));

    always_comb begin
        prod_next = prod_full[MAC_WIDTH-1:0];
`ifdef DISTANCE_MAC_SATURATE_EN
        if (prod_ovf) begin
            prod_next = prod_full[PW-1] ? NEG_MIN : POS_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
            s2_valid_reg <= 1'b0;
            s2_prod_reg  <= '0;
            s2_povf_reg  <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_prod_reg <= prod_next;
                s2_povf_reg <= prod_ovf;
            end
        end
    end

    // ---------------- S3: accumulate ----------------
    logic [MAC_WIDTH-1:0] acc_reg;
    logic [MAC_WIDTH-1:0] acc_base;
    logic [MAC_WIDTH-1:0] sum_wrap;
    logic [MAC_WIDTH-1:0] acc_next;
    logic                 add_ovf;
    logic                 last_band;
    logic [CNT_W-1:0]     band_cnt_reg;
    logic                 acc_valid_reg;
    logic                 acc_last_reg;
    logic                 ovf_reg;

    // Band 0 ignores the previous pixel's total, so pixels run back to back without a bubble.
    assign acc_base  = (band_cnt_reg == '0) ? '0 : acc_reg;
    assign sum_wrap  = acc_base + s2_prod_reg;
    assign add_ovf   = (acc_base[MAC_WIDTH-1] == s2_prod_reg[MAC_WIDTH-1]) &&
                       (sum_wrap[MAC_WIDTH-1] != acc_base[MAC_WIDTH-1]);
    assign last_band = (band_cnt_reg == LAST_BAND);

`ifdef DISTANCE_MAC_SATURATE_EN
    logic sat_lock_reg;
    logic sat_lock_next;

    // Once the sum has clamped it is frozen until the pixel's last band.
    always_comb begin
        acc_next      = sum_wrap;
        sat_lock_next = sat_lock_reg;
        if (sat_lock_reg) begin
            acc_next = acc_reg;
        end else if (add_ovf) begin
            acc_next      = acc_base[MAC_WIDTH-1] ? NEG_MIN : POS_MAX;
            sat_lock_next = 1'b1;
        end
        if (last_band) begin
            sat_lock_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
            sat_lock_reg <= 1'b0;
        end else if (s2_valid_reg) begin
            sat_lock_reg <= sat_lock_next;
        end
    end
`else
    assign acc_next = sum_wrap;
`endif

    always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
            acc_reg       <= '0;
            band_cnt_reg  <= '0;
            acc_valid_reg <= 1'b0;
            acc_last_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            acc_valid_reg <= s2_valid_reg;
            acc_last_reg  <= s2_valid_reg && last_band;
            if (s2_valid_reg) begin
                acc_reg      <= acc_next;
                band_cnt_reg <= last_band ? '0 : band_cnt_reg + 1'b1;
                if (s2_povf_reg || add_ovf) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign acc_out   = acc_reg;
    assign acc_valid = acc_valid_reg;
    assign acc_last  = acc_last_reg;
    assign overflow  = ovf_reg;

endmodule
